// File: rtl/gen_clk_pkg.sv
// Shared encodings for the clk_8f divider start-up sequencer: FSM states,
// fault cause codes and the widths of the internal counters.
package gen_clk_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        WARM  = 3'd2,
        CHECK = 3'd3,
        RUN   = 3'd4,
        FAULT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_TIMEOUT = 2'd1,
        FC_PERIOD  = 2'd2,
        FC_PHASE   = 2'd3
    } fault_code_t;

    localparam int             GAP_W   = 4;
    localparam logic [GAP_W-1:0] GAP_MAX = 4'd15;
    localparam int             CNT_W   = 8;

endpackage

// File: rtl/clk_edge_mon.sv
// Samples one divided clock on clk_8f, detects its edges and measures the
// gap between them with a saturating counter.
module clk_edge_mon
    import gen_clk_pkg::*;
#(
    parameter int HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    output logic edge_det,
    output logic gap_err,
    output logic missing
);

    logic             q_q, q_d;
    logic             p_q, p_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    // The gap judged at an edge is the count before it reloads to 1.
    always_comb begin
        q_d      = clk_in;
        p_d      = q_q;
        edge_det = q_q ^ p_q;
        gap_d    = gap_q;
        if (edge_det) begin
            gap_d = GAP_W'(1);
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + GAP_W'(1);
        end
        gap_err = edge_det && (gap_q != GAP_W'(HALF));
        missing = !edge_det && (gap_q > GAP_W'(HALF));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= 1'b0;
            p_q   <= 1'b0;
            gap_q <= '0;
        end else begin
            q_q   <= q_d;
            p_q   <= p_d;
            gap_q <= gap_d;
        end
    end

endmodule

// File: rtl/gen_clk_ctrl.sv
// Brings the clk_8f divider out of reset, verifies clk_2f/clk_f period and
// alignment, then asserts clk_ok; any deviation latches a sticky fault.
module gen_clk_ctrl
    import gen_clk_pkg::*;
#(
    parameter int HOLD_CYC    = 4,
    parameter int TIMEOUT     = 16,
    parameter int CHECK_EDGES = 3,
    parameter int F_HALF      = 4,
    parameter int F2_HALF     = 2
) (
    input  logic       clk_8f,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       clk_2f,
    input  logic       clk_f,
    output logic       div_rst,
    output logic       div_enb,
    output logic       clk_ok,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state
);

    logic f_edge, f_gap_err, f_missing;
    logic f2_edge, f2_gap_err, f2_missing;
    logic f_phase, f_period;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] good_q, good_d;
    fault_code_t      fault_code_q, fault_code_d;
    logic             div_rst_q, div_rst_d;
    logic             div_enb_q, div_enb_d;
    logic             clk_ok_q, clk_ok_d;
    logic             fault_q, fault_d;

    clk_edge_mon #(.HALF(F_HALF)) u_mon_f (
        .clk      (clk_8f),
        .rst      (rst),
        .clk_in   (clk_f),
        .edge_det (f_edge),
        .gap_err  (f_gap_err),
        .missing  (f_missing)
    );

    clk_edge_mon #(.HALF(F2_HALF)) u_mon_f2 (
        .clk      (clk_8f),
        .rst      (rst),
        .clk_in   (clk_2f),
        .edge_det (f2_edge),
        .gap_err  (f2_gap_err),
        .missing  (f2_missing)
    );

    assign f_phase  = f_edge && !f2_edge;
    assign f_period = f_gap_err || f_missing || f2_gap_err || f2_missing;

    always_comb begin
        state_d      = state_q;
        cyc_d        = '0;
        good_d       = good_q;
        fault_code_d = fault_code_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) state_d = HOLD;
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cyc_q == CNT_W'(HOLD_CYC - 1)) begin
                    state_d = WARM;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            WARM: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (f_edge) begin
                    if (f2_edge) begin
                        state_d = CHECK;
                        good_d  = '0;
                    end else begin
                        state_d      = FAULT;
                        fault_code_d = FC_PHASE;
                    end
                end else if (cyc_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d      = FAULT;
                    fault_code_d = FC_TIMEOUT;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            CHECK, RUN: begin
                // Phase errors outrank period errors when both appear at once.
                if (stop) begin
                    state_d = IDLE;
                end else if (f_phase) begin
                    state_d      = FAULT;
                    fault_code_d = FC_PHASE;
                end else if (f_period) begin
                    state_d      = FAULT;
                    fault_code_d = FC_PERIOD;
                end else if (f_edge && (state_q == CHECK)) begin
                    good_d = good_q + CNT_W'(1);
                    if (good_q == CNT_W'(CHECK_EDGES - 1)) state_d = RUN;
                end
            end
            FAULT: begin
                if (clear) begin
                    state_d      = IDLE;
                    fault_code_d = FC_NONE;
                end
            end
            default: begin
                state_d      = IDLE;
                fault_code_d = FC_NONE;
            end
        endcase

        // Outputs follow the state being entered so they register with it.
        div_rst_d = 1'b1;
        div_enb_d = 1'b0;
        clk_ok_d  = 1'b0;
        fault_d   = 1'b0;
        case (state_d)
            WARM, CHECK: begin
                div_rst_d = 1'b0;
                div_enb_d = 1'b1;
            end
            RUN: begin
                div_rst_d = 1'b0;
                div_enb_d = 1'b1;
                clk_ok_d  = 1'b1;
            end
            FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                div_rst_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_8f or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            good_q       <= '0;
            fault_code_q <= FC_NONE;
            div_rst_q    <= 1'b1;
            div_enb_q    <= 1'b0;
            clk_ok_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            good_q       <= good_d;
            fault_code_q <= fault_code_d;
            div_rst_q    <= div_rst_d;
            div_enb_q    <= div_enb_d;
            clk_ok_q     <= clk_ok_d;
            fault_q      <= fault_d;
        end
    end

    assign div_rst    = div_rst_q;
    assign div_enb    = div_enb_q;
    assign clk_ok     = clk_ok_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign state      = state_q;

endmodule

// File: tb/tb_gen_clk_ctrl.sv
// Bench for gen_clk_ctrl: a behavioural divider model feeds the monitor and
// per-cycle expected output vectors are queued and compared.
module tb_gen_clk_ctrl;

    logic       clk_8f = 1'b0;
    logic       rst    = 1'b0;
    logic       start  = 1'b0;
    logic       stop   = 1'b0;
    logic       clear  = 1'b0;
    logic       clk_2f = 1'b0;
    logic       clk_f  = 1'b0;
    logic       div_rst, div_enb, clk_ok, fault;
    logic [1:0] fault_code;
    logic [2:0] state;

    // Vector layout: {state, div_rst, div_enb, clk_ok, fault, fault_code}
    localparam logic [8:0] V_IDLE  = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    localparam logic [8:0] V_HOLD  = {3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    localparam logic [8:0] V_WARM  = {3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    localparam logic [8:0] V_CHECK = {3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    localparam logic [8:0] V_RUN   = {3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    localparam logic [8:0] V_F_TO  = {3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    localparam logic [8:0] V_F_PER = {3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
    localparam logic [8:0] V_F_PH  = {3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3};

    localparam int MODE_OK    = 0;
    localparam int MODE_STUCK = 1;
    localparam int MODE_PHASE = 2;

    int         checks   = 0;
    int         failures = 0;
    string      cur_tag  = "reset";
    logic [8:0] exp_q[$];

    int         mode        = MODE_OK;
    logic [2:0] dcnt        = 3'd0;
    logic       stretch_req = 1'b0;

    gen_clk_ctrl dut (
        .clk_8f     (clk_8f),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .clk_2f     (clk_2f),
        .clk_f      (clk_f),
        .div_rst    (div_rst),
        .div_enb    (div_enb),
        .clk_ok     (clk_ok),
        .fault      (fault),
        .fault_code (fault_code),
        .state      (state)
    );

    always #5 clk_8f = ~clk_8f;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%b expected=%b", tag, $time, got, exp);
        end
    endtask

    // Divide-by-8 counter; a stretch request pauses both outputs for one cycle.
    task automatic model_update();
        if (div_rst) begin
            dcnt = 3'd0;
        end else if (div_enb) begin
            if (stretch_req && dcnt == 3'd3) stretch_req = 1'b0;
            else dcnt = dcnt + 3'd1;
        end
        case (mode)
            MODE_STUCK: begin clk_2f = 1'b0;    clk_f = 1'b0;    end
            MODE_PHASE: begin clk_2f = 1'b0;    clk_f = dcnt[2]; end
            default:    begin clk_2f = dcnt[1]; clk_f = dcnt[2]; end
        endcase
    endtask

    task automatic sample();
        logic [8:0] exp;
        logic [8:0] obs;
        obs = {state, div_rst, div_enb, clk_ok, fault, fault_code};
        if (exp_q.size() == 0) begin
            check_eq({cur_tag, "_queue_empty"}, obs, ~obs);
        end else begin
            exp = exp_q.pop_front();
            check_eq(cur_tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_8f);
        #1;
        model_update();
        sample();
    endtask

    task automatic expect_n(input logic [8:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v);
            cyc();
        end
    endtask

    task automatic bring_up(input int run_n);
        start = 1'b1;
        expect_n(V_HOLD, 1);
        start = 1'b0;
        expect_n(V_HOLD, 3);
        expect_n(V_WARM, 5);
        expect_n(V_CHECK, 12);
        expect_n(V_RUN, run_n);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        expect_n(V_IDLE, 1);
        clear = 1'b0;
        expect_n(V_IDLE, 2);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        exp_q.push_back(V_IDLE);
        sample();
        #8 rst = 1'b0;

        // Clean bring-up to RUN.
        cur_tag = "s1_bringup";
        mode = MODE_OK;
        bring_up($urandom_range(4, 10));

        // One stretched divider half-period while running.
        cur_tag = "s3_stretch";
        stretch_req = 1'b1;
        for (int i = 0; i < 12 && stretch_req; i++) begin
            exp_q.push_back(V_RUN);
            cyc();
        end
        check_eq("s3_stretch_applied", {8'd0, stretch_req}, 9'd0);
        expect_n(V_RUN, 2);
        expect_n(V_F_PER, 1);
        cur_tag = "s3_fault_sticky";
        stop = 1'b1;
        expect_n(V_F_PER, 2);
        stop = 1'b0;
        cur_tag = "s3_clear";
        do_clear();

        // Divider outputs stuck low.
        cur_tag = "s2_timeout";
        mode = MODE_STUCK;
        start = 1'b1;
        expect_n(V_HOLD, 1);
        start = 1'b0;
        expect_n(V_HOLD, 3);
        expect_n(V_WARM, 16);
        expect_n(V_F_TO, 1);
        start = 1'b1;
        expect_n(V_F_TO, 1);
        start = 1'b0;
        cur_tag = "s2_clear";
        do_clear();

        // clk_f toggles while clk_2f stays flat.
        cur_tag = "s4_phase";
        mode = MODE_PHASE;
        start = 1'b1;
        expect_n(V_HOLD, 1);
        start = 1'b0;
        expect_n(V_HOLD, 3);
        expect_n(V_WARM, 5);
        expect_n(V_F_PH, 2);
        cur_tag = "s4_clear";
        do_clear();

        // stop from RUN, then start+stop together in IDLE.
        cur_tag = "s5_bringup";
        mode = MODE_OK;
        bring_up($urandom_range(2, 8));
        cur_tag = "s5_stop";
        stop = 1'b1;
        expect_n(V_IDLE, 1);
        start = 1'b1;
        expect_n(V_IDLE, 3);
        start = 1'b0;
        stop  = 1'b0;
        expect_n(V_IDLE, 2);

        // Asynchronous reset in the middle of CHECK.
        cur_tag = "s6_pre_reset";
        start = 1'b1;
        expect_n(V_HOLD, 1);
        start = 1'b0;
        expect_n(V_HOLD, 3);
        expect_n(V_WARM, 5);
        expect_n(V_CHECK, $urandom_range(2, 8));
        #3 rst = 1'b1;
        #1;
        cur_tag = "s6_async_reset";
        exp_q.push_back(V_IDLE);
        sample();
        expect_n(V_IDLE, 2);
        #3 rst = 1'b0;
        cur_tag = "s6_rebringup";
        bring_up(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
